// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: RISC-V M funct3
// encodings, controller states and operand-signedness predicates.
package muldiv_pkg;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PREP = 2'd1,
      ST_RUN  = 2'd2,
      ST_FIX  = 2'd3
   } state_t;

   function automatic logic is_div(input logic [2:0] op);
      return op[2];
   endfunction

   // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
   function automatic logic a_signed(input logic [2:0] op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   // rs2 is treated as signed for MULH, DIV and REM.
   function automatic logic b_signed(input logic [2:0] op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift/add multiplier or restoring divider.
// P is W+1 bits: its top bit carries the multiply carry, or the freshly
// resolved quotient bit, from the add half to the shift half.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int W   = 32,
   parameter int CPB = 2
) (
   input  logic [W:0]   p,
   input  logic [W-1:0] m,
   input  logic [W-1:0] mag_b,
   input  logic         mode,    // 1 = divide, 0 = multiply
   input  logic         phase,   // CPB=2 only: 0 = add/trial half, 1 = shift half
   output logic [W:0]   p_next,
   output logic [W-1:0] m_next
);

   logic [W:0]   sum;
   logic [W:0]   pext;
   logic [W-1:0] diff;
   logic         no_borrow;
   logic [W:0]   add_p;
   logic [W:0]   sh_in_p;
   logic [W:0]   sh_p;
   logic [W-1:0] sh_m;
   logic         do_shift;

   // Add half: conditional add of |b|, or trial subtract of |b| from the
   // left-shifted partial remainder {P, M[W-1]}.
   always_comb begin
      sum       = {1'b0, p[W-1:0]} + {1'b0, mag_b};
      pext      = {p[W-1:0], m[W-1]};
      no_borrow = (pext >= {1'b0, mag_b});
      // A successful trial leaves a remainder below |b|, so W bits suffice.
      diff      = pext[W-1:0] - mag_b;
      if (mode) begin
         add_p = no_borrow ? {1'b1, diff} : {1'b0, pext[W-1:0]};
      end else begin
         add_p = m[0] ? sum : p;
      end
   end

   // Shift half: right shift of {C,P,M} for multiply, left shift of M with
   // the quotient bit entering for divide.
   always_comb begin
      sh_in_p = (CPB == 1) ? add_p : p;
      if (mode) begin
         sh_p = {1'b0, sh_in_p[W-1:0]};
         sh_m = {m[W-2:0], sh_in_p[W]};
      end else begin
         sh_p = {1'b0, sh_in_p[W:1]};
         sh_m = {sh_in_p[0], m[W-1:1]};
      end
   end

   assign do_shift = (CPB == 1) || phase;
   assign p_next   = do_shift ? sh_p : add_p;
   assign m_next   = do_shift ? sh_m : m;

endmodule

// File: rtl/seq_muldiv.sv
// Iterative RISC-V M-extension multiply/divide unit with start/busy/done
// handshake. Fixed latency: done rises CPB*W+3 edges after start is sampled.
module seq_muldiv
   import muldiv_pkg::*;
#(
   parameter int W   = 32,
   parameter int CPB = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [2:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result,
   output logic [1:0]   dbg_state
);

   localparam int           CW      = $clog2(W);
   localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

   state_t         state, state_next;
   logic [2:0]     op_r;
   logic [W-1:0]   a_r, b_r, mag_b, m;
   logic [W:0]     p;
   logic [CW-1:0]  cnt;
   logic           phase, neg_res, div_zero, div_ovf;

   logic           sa, sb, neg_c, ovf_c;
   logic [W-1:0]   mag_a_c, mag_b_c;
   logic [W:0]     p_step;
   logic [W-1:0]   m_step;
   logic           tick, last_step;
   logic [2*W-1:0] prod;
   logic [W-1:0]   quo, rem, fix_result;

   // State register.
   // NOTE: reset is synchronous, so rst is tested inside the clocked branch and
   // kept out of the sensitivity list; <= makes every flop sample pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   // Next-state logic and status outputs.
   // NOTE: every output gets a default first so no path can infer a latch.
   always_comb begin
      state_next = state;
      busy       = (state != ST_IDLE);
      dbg_state  = state;
      case (state)
         ST_IDLE: if (start) state_next = ST_PREP;
         ST_PREP: state_next = ST_RUN;
         ST_RUN:  if (last_step) state_next = ST_FIX;
         ST_FIX:  state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Sign, magnitude and special-case decode of the latched operands.
   always_comb begin
      sa      = a_signed(op_r) & a_r[W-1];
      sb      = b_signed(op_r) & b_r[W-1];
      mag_a_c = sa ? -a_r : a_r;
      mag_b_c = sb ? -b_r : b_r;
      // Remainder takes the dividend's sign; products and quotients take sa^sb.
      neg_c   = (is_div(op_r) && op_r[1]) ? sa : (sa ^ sb);
      ovf_c   = is_div(op_r) && !op_r[0] && (a_r == MIN_NEG) && (b_r == '1);
   end

   // The bit counter moves once per full iteration (on the shift half).
   assign tick      = (CPB == 1) || phase;
   assign last_step = (state == ST_RUN) && tick && (cnt == '0);

   muldiv_step #(.W(W), .CPB(CPB)) u_step (
      .p      (p),
      .m      (m),
      .mag_b  (mag_b),
      .mode   (is_div(op_r)),
      .phase  (phase),
      .p_next (p_step),
      .m_next (m_step)
   );

   // Sign fix-up and RISC-V divide special cases, selected per op.
   always_comb begin
      prod = {p[W-1:0], m};
      if (neg_res) prod = -prod;
      quo = neg_res ? -m : m;
      rem = neg_res ? -p[W-1:0] : p[W-1:0];
      if (div_zero) begin
         quo = '1;
         rem = a_r;
      end else if (div_ovf) begin
         quo = a_r;
         rem = '0;
      end
      case (op_r)
         OP_MUL:                       fix_result = prod[W-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod[2*W-1:W];
         OP_DIV, OP_DIVU:              fix_result = quo;
         default:                      fix_result = rem;
      endcase
   end

   // Operand capture, accumulator iteration and result/done registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_r     <= '0;
         a_r      <= '0;
         b_r      <= '0;
         mag_b    <= '0;
         p        <= '0;
         m        <= '0;
         cnt      <= '0;
         phase    <= 1'b0;
         neg_res  <= 1'b0;
         div_zero <= 1'b0;
         div_ovf  <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
      end else begin
         done <= (state == ST_FIX);
         case (state)
            ST_IDLE: begin
               if (start) begin
                  op_r <= op;
                  a_r  <= a;
                  b_r  <= b;
               end
            end
            ST_PREP: begin
               p        <= '0;
               m        <= mag_a_c;
               mag_b    <= mag_b_c;
               neg_res  <= neg_c;
               div_zero <= (b_r == '0);
               div_ovf  <= ovf_c;
               cnt      <= CW'(W - 1);
               phase    <= 1'b0;
            end
            ST_RUN: begin
               p <= p_step;
               m <= m_step;
               if (CPB == 2) phase <= ~phase;
               if (tick) cnt <= cnt - 1'b1;
            end
            ST_FIX: result <= fix_result;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_muldiv.sv
// Self-checking bench for seq_muldiv: an 8-bit CPB=2 instance and a 4-bit
// CPB=1 instance, each checked every cycle against a queue of expectations
// produced by a plain-arithmetic reference model.
module tb_seq_muldiv;
   import muldiv_pkg::*;

   localparam int LAT8 = 2 * 8 + 3;
   localparam int LAT4 = 1 * 4 + 3;

   typedef struct {
      logic [31:0] res;
      int          start_edge;
      int          done_edge;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start8 = 1'b0, start4 = 1'b0;
   logic [2:0] op8 = '0, op4 = '0;
   logic [7:0] a8 = '0, b8 = '0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       busy8, done8, busy4, done4;
   logic [7:0] result8;
   logic [3:0] result4;
   logic [1:0] st8, st4;

   exp_t        q8[$];
   exp_t        q4[$];
   logic [31:0] last8 = '0, last4 = '0;
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   seq_muldiv #(.W(8), .CPB(2)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .result(result8), .dbg_state(st8)
   );

   seq_muldiv #(.W(4), .CPB(1)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .op(op4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .result(result4), .dbg_state(st4)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: RISC-V M semantics with signed 64-bit integer arithmetic.
   function automatic logic [31:0] ref_op(input int w, input logic [2:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
      longint mask, half, ua, ub, sa, sb, r;
      mask = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      ua   = longint'({32'd0, a}) & mask;
      ub   = longint'({32'd0, b}) & mask;
      sa   = (ua >= half) ? ua - (mask + 1) : ua;
      sb   = (ub >= half) ? ub - (mask + 1) : ub;
      case (op)
         OP_MUL:    r = sa * sb;
         OP_MULH:   r = (sa * sb) >>> w;
         OP_MULHSU: r = (sa * ub) >>> w;
         OP_MULHU:  r = (ua * ub) >>> w;
         OP_DIV:    r = (ub == 0) ? -1 : (sa == -half && sb == -1) ? sa : sa / sb;
         OP_DIVU:   r = (ub == 0) ? -1 : ua / ub;
         OP_REM:    r = (ub == 0) ? sa : (sa == -half && sb == -1) ? 0 : sa % sb;
         default:   r = (ub == 0) ? ua : ua % ub;
      endcase
      return 32'(r & mask);
   endfunction

   // Compare process for the 8-bit unit: busy window, done timing, result, hold.
   always @(negedge clk) begin
      exp_t e;
      logic exp_busy;
      if (!rst) begin
         exp_busy = (q8.size() > 0) && (cyc >= q8[0].start_edge) && (cyc < q8[0].done_edge);
         check("busy8", 32'(busy8), 32'(exp_busy));
         if (done8) begin
            if (q8.size() == 0) begin
               check("spurious_done8", 32'(done8), 32'd0);
            end else begin
               e = q8.pop_front();
               check("done_edge8", cyc, e.done_edge);
               check("result8", 32'(result8), e.res);
               last8 = e.res;
            end
         end else begin
            check("hold8", 32'(result8), last8);
            if (q8.size() > 0 && cyc >= q8[0].done_edge) begin
               check("missing_done8", 32'(done8), 32'd1);
               void'(q8.pop_front());
            end
         end
      end
   end

   // Compare process for the 4-bit CPB=1 unit.
   always @(negedge clk) begin
      exp_t e;
      logic exp_busy;
      if (!rst) begin
         exp_busy = (q4.size() > 0) && (cyc >= q4[0].start_edge) && (cyc < q4[0].done_edge);
         check("busy4", 32'(busy4), 32'(exp_busy));
         if (done4) begin
            if (q4.size() == 0) begin
               check("spurious_done4", 32'(done4), 32'd0);
            end else begin
               e = q4.pop_front();
               check("done_edge4", cyc, e.done_edge);
               check("result4", 32'(result4), e.res);
               last4 = e.res;
            end
         end else begin
            check("hold4", 32'(result4), last4);
            if (q4.size() > 0 && cyc >= q4[0].done_edge) begin
               check("missing_done4", 32'(done4), 32'd1);
               void'(q4.pop_front());
            end
         end
      end
   end

   task automatic wait_empty8();
      int n = 0;
      while (q8.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (q8.size() != 0) begin
         check("timeout8", q8.size(), 0);
         q8.delete();
      end
   endtask

   task automatic wait_empty4();
      int n = 0;
      while (q4.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (q4.size() != 0) begin
         check("timeout4", q4.size(), 0);
         q4.delete();
      end
   endtask

   // Issue one operation; operands are scrambled right after acceptance.
   task automatic run8(input string name, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input bit has_lit, input logic [7:0] lit);
      exp_t e;
      @(negedge clk);
      start8 = 1'b1; op8 = op; a8 = a; b8 = b;
      e.res = ref_op(8, op, 32'(a), 32'(b));
      e.start_edge = cyc + 1;
      e.done_edge  = e.start_edge + LAT8 - 1;
      q8.push_back(e);
      @(negedge clk);
      start8 = 1'b0; op8 = ~op; a8 = ~a; b8 = a ^ 8'h5A;
      wait_empty8();
      if (has_lit) check({"lit_", name}, 32'(result8), 32'(lit));
   endtask

   task automatic run4(input string name, input logic [2:0] op, input logic [3:0] a,
                       input logic [3:0] b, input bit has_lit, input logic [3:0] lit);
      exp_t e;
      @(negedge clk);
      start4 = 1'b1; op4 = op; a4 = a; b4 = b;
      e.res = ref_op(4, op, 32'(a), 32'(b));
      e.start_edge = cyc + 1;
      e.done_edge  = e.start_edge + LAT4 - 1;
      q4.push_back(e);
      @(negedge clk);
      start4 = 1'b0; op4 = ~op; a4 = ~a; b4 = a ^ 4'h5;
      wait_empty4();
      if (has_lit) check({"lit_", name}, 32'(result4), 32'(lit));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached at edge %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e1, e2;
      int   s;
      logic [7:0] va [8] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h37, 8'hC5, 8'h80};
      logic [7:0] vb [8] = '{8'h00, 8'hFF, 8'h80, 8'hFF, 8'h01, 8'hC5, 8'h07, 8'h00};

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_busy8", 32'(busy8), 32'd0);
      check("rst_done8", 32'(done8), 32'd0);
      check("rst_result8", 32'(result8), 32'd0);
      check("rst_state8", 32'(st8), 32'd0);
      check("rst_state4", 32'(st4), 32'd0);
      check("rst_result4", 32'(result4), 32'd0);
      rst = 1'b0;

      // Directed vectors with hand-computed results.
      run8("mul",    OP_MUL,    8'hFD, 8'h05, 1'b1, 8'hF1);
      run8("mulh",   OP_MULH,   8'hFD, 8'h05, 1'b1, 8'hFF);
      run8("mulhu",  OP_MULHU,  8'hFF, 8'hFF, 1'b1, 8'hFE);
      run8("mulhsu", OP_MULHSU, 8'hFF, 8'hFF, 1'b1, 8'hFF);
      run8("div",    OP_DIV,    8'hF9, 8'h02, 1'b1, 8'hFD);
      run8("rem",    OP_REM,    8'hF9, 8'h02, 1'b1, 8'hFF);
      run8("divu0",  OP_DIVU,   8'hC8, 8'h00, 1'b1, 8'hFF);
      run8("remu0",  OP_REMU,   8'hC8, 8'h00, 1'b1, 8'hC8);
      run8("divovf", OP_DIV,    8'h80, 8'hFF, 1'b1, 8'h80);
      run8("removf", OP_REM,    8'h80, 8'hFF, 1'b1, 8'h00);
      run4("mulhu4", OP_MULHU,  4'hF, 4'hF, 1'b1, 4'hE);
      run4("divu4",  OP_DIVU,   4'hD, 4'h3, 1'b1, 4'h4);
      run4("remu4",  OP_REMU,   4'hD, 4'h3, 1'b1, 4'h1);

      // A second start pulsed on edge 5 of a busy operation is ignored.
      @(negedge clk);
      start8 = 1'b1; op8 = OP_MUL; a8 = 8'h13; b8 = 8'h0B;
      e1.res = 32'h0000_00D1; e1.start_edge = cyc + 1; e1.done_edge = e1.start_edge + LAT8 - 1;
      q8.push_back(e1);
      s = e1.start_edge;
      @(negedge clk);
      start8 = 1'b0;
      while (cyc < s + 3) @(negedge clk);
      start8 = 1'b1; op8 = OP_DIVU; a8 = 8'h11; b8 = 8'h22;
      @(negedge clk);
      start8 = 1'b0;
      wait_empty8();
      check("lit_ignored_start", 32'(result8), 32'h0000_00D1);

      // start held through the done cycle: second operation runs back to back.
      @(negedge clk);
      start8 = 1'b1; op8 = OP_MUL; a8 = 8'hFD; b8 = 8'h05;
      e1.res = 32'h0000_00F1; e1.start_edge = cyc + 1; e1.done_edge = e1.start_edge + 18;
      e2.res = 32'h0000_00FD; e2.start_edge = cyc + 20; e2.done_edge = e2.start_edge + 18;
      q8.push_back(e1);
      q8.push_back(e2);
      s = e1.start_edge;
      @(negedge clk);
      op8 = OP_DIV; a8 = 8'hF9; b8 = 8'h02;
      while (cyc < s + 19) @(negedge clk);
      start8 = 1'b0;
      wait_empty8();
      check("lit_back_to_back", 32'(result8), 32'h0000_00FD);

      // Reset on edge 10 of an operation aborts it: no done, result cleared.
      @(negedge clk);
      start8 = 1'b1; op8 = OP_DIVU; a8 = 8'hC8; b8 = 8'h07;
      e1.res = 32'(8'h1C); e1.start_edge = cyc + 1; e1.done_edge = e1.start_edge + LAT8 - 1;
      q8.push_back(e1);
      s = e1.start_edge;
      @(negedge clk);
      start8 = 1'b0;
      while (cyc < s + 8) @(negedge clk);
      rst = 1'b1; q8.delete(); q4.delete(); last8 = '0; last4 = '0;
      @(negedge clk);
      check("abort_busy8", 32'(busy8), 32'd0);
      check("abort_done8", 32'(done8), 32'd0);
      check("abort_result8", 32'(result8), 32'd0);
      check("abort_state8", 32'(st8), 32'd0);
      rst = 1'b0;
      repeat (25) @(negedge clk);

      // Boundary operand pairs on every op against the model.
      for (int o = 0; o < 8; o++)
         for (int j = 0; j < 8; j++)
            run8("sweep8", 3'(o), va[j], vb[j], 1'b0, 8'h00);

      // Exhaustive 4-bit sweep on the single-cycle-per-bit instance.
      for (int o = 0; o < 8; o++)
         for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
               run4("sweep4", 3'(o), 4'(x), 4'(y), 1'b0, 4'h0);

      repeat (5) @(negedge clk);
      check("drained8", q8.size(), 0);
      check("drained4", q4.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_muldiv.md
Name: seq_muldiv

Overview:
- Parametrised, iterative multiply/divide unit covering the full RISC-V M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) at width W.
- Next generation of our small shift/add prototype.
- Adds its own control FSM, a start/busy/done handshake, signed operand fix-up, RISC-V divide-by-zero and overflow semantics, and a selectable one or two cycles per bit.
- Sits beside the main ALU in the midgetv datapath; the core stalls on busy.

Parameters:
- W, 32, operand and result width; legal range 4..32.
- CPB, 2, cycles per bit: 1 = add+shift in one cycle; 2 = separate add cycle then shift cycle, matching the midgetv microsequence.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  request; sampled only in IDLE
- op  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  in  W  rs1 operand (multiplicand / dividend)
- b  in  W  rs2 operand (multiplier / divisor)
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; result valid
- result  out  W  registered result; holds until the next accepted start
- dbg_state  out  2  current FSM state, for the bench only

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, busy=0, done=0, result=0; all internal registers cleared. Reset mid-operation aborts it; no done pulse is produced.
- Clock and reset: one clock, clk; reset is synchronous and active-high; the port is rst.
- States: IDLE(0), PREP(1), RUN(2), FIX(3).
- IDLE:
  - start=1 latches op, a, b; next state PREP.
  - done=1 only in the cycle directly after FIX.
- PREP (1 cycle):
  - Records the operand signs: a is signed for MULH, MULHSU, DIV, REM; b is signed for MULH, DIV, REM.
  - Stores |a| and |b|.
  - Records negate_result: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
  - Records special-case flags: b==0, and (a==100..0 && b==all-ones && signed divide).
  - Clears the 2W-bit accumulator {P,M}; M gets |a| for multiply and |a| for divide.
- RUN (exactly CPB*W cycles; bit counter counts W-1 down to 0):
  - Multiply: if M[0], P += |b|, with the carry kept in a W+1 bit sum; then {C,P,M} shifts right by one.
  - Divide (restoring): {P,M} shifts left by one; trial = P - |b|; if there is no borrow, P = trial and M[0] = 1.
  - CPB=2: the even cycle does add/trial and the odd cycle does the shift; the counter decrements on odd cycles only.
  - CPB=1: both in one cycle.
- FIX (1 cycle):
  - Selects P or M per op and applies two's-complement negation if negate_result.
  - Special cases override:
    - Divide by zero: quotient = all ones; remainder = original a.
    - Signed overflow: quotient = original a; remainder = 0.
  - Next edge: result is written, done=1, busy=0, state=IDLE.
- Latency is fixed and data-independent: done is high after clk edge number CPB*W+3, counting the edge that sampled start as 1. The special cases take the same latency.
- start while busy is ignored; there is no queuing. start in the done cycle is accepted (back-to-back operation).
- Changes on a and b after acceptance have no effect.
- All arithmetic is unsigned on magnitudes; the W+1 bit carry/borrow is internal only.
- MUL returns the low word. MULH, MULHSU and MULHU return the high word of the 2W signed/mixed/unsigned product.

Decomposition:
- Package muldiv_pkg:
  - op encodings (OP_MUL..OP_REMU) as 3-bit localparams;
  - state enum values ST_IDLE..ST_FIX;
  - helper predicates is_div(op), a_signed(op), b_signed(op).
- One sub-module, muldiv_step: combinational single-iteration datapath.
  - Inputs: P, M, |b|, mode, phase.
  - Outputs: next P, next M.
  - Instantiated once; the FSM and counter stay in seq_muldiv.

Test Plan (W=8, CPB=2 unless stated; latency 19 edges):
- MUL/MULH, a=0xFD (-3), b=0x05 -> MUL result 0xF1; MULH result 0xFF; done on edge 19; busy high for edges 1..18.
- MULHU a=0xFF, b=0xFF -> 0xFE. MULHSU a=0xFF (-1), b=0xFF (255) -> 0xFF.
- DIV a=0xF9 (-7), b=0x02 -> 0xFD. REM, same operands -> 0xFF.
- DIVU a=0xC8, b=0x00 -> 0xFF. REMU, same operands -> 0xC8. DIV a=0x80, b=0xFF -> 0x80. REM, same operands -> 0x00. All with latency 19.
- Handshake:
  - start pulsed again at edge 5 is ignored; result is unchanged until edge 19.
  - start held high through the done cycle -> second op accepted; second done at edge 38.
  - rst asserted at edge 10 -> busy=0, result=0, no done.
- CPB=1, W=4: MULHU a=0xF, b=0xF -> 0xE, done at edge 7. DIVU a=0xD, b=0x3 -> 0x4. REMU, same operands -> 0x1.
